// File: rtl/decode_stage.sv
// decode_stage: RV32I integer-subset decode stage.
// Decodes the fetch stage's registered PC/instruction pair and reads the register
// file, with a same-cycle bypass from write-back. JAL, JALR and taken branches are
// resolved combinationally so that fetch can redirect without a bubble. The decoded
// operands and control bits are captured in the ID/EX pipeline register.
module decode_stage #(
  parameter int          XLEN            = 32,
  parameter logic [31:0] RESET_PC_BUBBLE = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC,
  input  logic [31:0]     instruction,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            jump_out,
  output logic [XLEN-1:0] offset_out,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_alu_imm,
  output logic            ex_link,
  output logic            ex_auipc,
  output logic            ex_lui,
  output logic            illegal_flag,
  output logic [31:0]     instr_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] regs_r [32];

  logic [6:0]      opcode_s;
  logic [4:0]      rd_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [2:0]      funct3_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;
  logic [XLEN-1:0] jalr_target_s;
  logic            br_taken_s;

  logic            legal_op_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [4:0]      dec_rd_s;
  logic            dec_reg_write_s;
  logic            dec_mem_read_s;
  logic            dec_mem_write_s;
  logic            dec_alu_imm_s;
  logic            dec_link_s;
  logic            dec_auipc_s;
  logic            dec_lui_s;
  logic            is_jal_s;
  logic            is_jalr_s;
  logic            is_branch_s;
  logic            is_bubble_s;
  logic            dec_valid_s;
  logic            dec_illegal_s;

  assign opcode_s = instruction[6:0];
  assign rd_s     = instruction[11:7];
  assign funct3_s = instruction[14:12];
  assign rs1_s    = instruction[19:15];
  assign rs2_s    = instruction[24:20];

  assign imm_i_s = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b_s = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u_s = {instruction[31:12], 12'h000};
  assign imm_j_s = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

  // JALR target has bit 0 forced low before the PC-relative offset is formed
  assign jalr_target_s = (rs1_data_s + imm_i_s) & 32'hFFFF_FFFE;

  assign is_bubble_s   = (instruction == RESET_PC_BUBBLE);
  assign dec_valid_s   = !is_bubble_s && legal_op_s;
  assign dec_illegal_s = !is_bubble_s && !legal_op_s;

  // Register-file reads: x0 is zero, a same-cycle write-back is bypassed to the reader
  always_comb begin
    rs1_data_s = 32'h0000_0000;
    rs2_data_s = 32'h0000_0000;
    if (rs1_s == 5'd0) begin
      rs1_data_s = 32'h0000_0000;
    end else if (wb_en && (wb_addr == rs1_s)) begin
      rs1_data_s = wb_data;
    end else begin
      rs1_data_s = regs_r[rs1_s];
    end
    if (rs2_s == 5'd0) begin
      rs2_data_s = 32'h0000_0000;
    end else if (wb_en && (wb_addr == rs2_s)) begin
      rs2_data_s = wb_data;
    end else begin
      rs2_data_s = regs_r[rs2_s];
    end
  end

  // Branch condition evaluated on the bypassed operands
  always_comb begin
    br_taken_s = 1'b0;
    case (funct3_s)
      3'b000:  br_taken_s = (rs1_data_s == rs2_data_s);
      3'b001:  br_taken_s = (rs1_data_s != rs2_data_s);
      3'b100:  br_taken_s = ($signed(rs1_data_s) <  $signed(rs2_data_s));
      3'b101:  br_taken_s = ($signed(rs1_data_s) >= $signed(rs2_data_s));
      3'b110:  br_taken_s = (rs1_data_s <  rs2_data_s);
      3'b111:  br_taken_s = (rs1_data_s >= rs2_data_s);
      default: br_taken_s = 1'b0;
    endcase
  end

  // Opcode decode into immediate selection and control bits
  always_comb begin
    legal_op_s      = 1'b1;
    dec_imm_s       = 32'h0000_0000;
    dec_rd_s        = 5'd0;
    dec_reg_write_s = 1'b0;
    dec_mem_read_s  = 1'b0;
    dec_mem_write_s = 1'b0;
    dec_alu_imm_s   = 1'b0;
    dec_link_s      = 1'b0;
    dec_auipc_s     = 1'b0;
    dec_lui_s       = 1'b0;
    is_jal_s        = 1'b0;
    is_jalr_s       = 1'b0;
    is_branch_s     = 1'b0;
    case (opcode_s)
      OP_LUI: begin
        dec_imm_s = imm_u_s; dec_rd_s = rd_s; dec_reg_write_s = 1'b1; dec_lui_s = 1'b1;
      end
      OP_AUIPC: begin
        dec_imm_s = imm_u_s; dec_rd_s = rd_s; dec_reg_write_s = 1'b1; dec_auipc_s = 1'b1;
      end
      OP_JAL: begin
        dec_imm_s = imm_j_s; dec_rd_s = rd_s; dec_reg_write_s = 1'b1; dec_link_s = 1'b1;
        is_jal_s = 1'b1;
      end
      OP_JALR: begin
        dec_imm_s = imm_i_s; dec_rd_s = rd_s; dec_reg_write_s = 1'b1; dec_link_s = 1'b1;
        is_jalr_s = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm_s   = imm_b_s;
        is_branch_s = 1'b1;
        // funct3 010/011 are not defined branch conditions
        if (funct3_s[2:1] == 2'b01) begin
          legal_op_s = 1'b0;
        end else begin
          legal_op_s = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_imm_s = imm_i_s; dec_rd_s = rd_s; dec_reg_write_s = 1'b1;
        dec_mem_read_s = 1'b1; dec_alu_imm_s = 1'b1;
      end
      OP_STORE: begin
        dec_imm_s = imm_s_s; dec_mem_write_s = 1'b1; dec_alu_imm_s = 1'b1;
      end
      OP_IMM: begin
        dec_imm_s = imm_i_s; dec_rd_s = rd_s; dec_reg_write_s = 1'b1; dec_alu_imm_s = 1'b1;
      end
      OP_OP: begin
        dec_rd_s = rd_s; dec_reg_write_s = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        legal_op_s = 1'b1;
      end
      default: begin
        legal_op_s = 1'b0;
      end
    endcase
  end

  // Zero-bubble redirect: offsets are relative to PC+4, which fetch adds itself
  always_comb begin
    jump_out   = 1'b0;
    offset_out = 32'h0000_0000;
    if (dec_valid_s && is_jal_s) begin
      jump_out   = 1'b1;
      offset_out = imm_j_s - 32'd4;
    end else if (dec_valid_s && is_jalr_s) begin
      jump_out   = 1'b1;
      offset_out = jalr_target_s - PC - 32'd4;
    end else if (dec_valid_s && is_branch_s && br_taken_s) begin
      jump_out   = 1'b1;
      offset_out = imm_b_s - 32'd4;
    end else begin
      jump_out   = 1'b0;
      offset_out = 32'h0000_0000;
    end
  end

  // Register file write port; reset wins over a concurrent write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // ID/EX pipeline register; bubbles and illegal instructions load an all-zero entry
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= 32'h0000_0000;
      ex_rs1_data  <= 32'h0000_0000;
      ex_rs2_data  <= 32'h0000_0000;
      ex_imm       <= 32'h0000_0000;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_imm   <= 1'b0;
      ex_link      <= 1'b0;
      ex_auipc     <= 1'b0;
      ex_lui       <= 1'b0;
    end else if (dec_valid_s) begin
      ex_valid     <= 1'b1;
      ex_pc        <= PC;
      ex_rs1_data  <= rs1_data_s;
      ex_rs2_data  <= rs2_data_s;
      ex_imm       <= dec_imm_s;
      ex_rd        <= dec_rd_s;
      ex_funct3    <= funct3_s;
      ex_funct7b5  <= instruction[30];
      ex_reg_write <= dec_reg_write_s;
      ex_mem_read  <= dec_mem_read_s;
      ex_mem_write <= dec_mem_write_s;
      ex_alu_imm   <= dec_alu_imm_s;
      ex_link      <= dec_link_s;
      ex_auipc     <= dec_auipc_s;
      ex_lui       <= dec_lui_s;
    end else begin
      ex_valid     <= 1'b0;
      ex_pc        <= 32'h0000_0000;
      ex_rs1_data  <= 32'h0000_0000;
      ex_rs2_data  <= 32'h0000_0000;
      ex_imm       <= 32'h0000_0000;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_imm   <= 1'b0;
      ex_link      <= 1'b0;
      ex_auipc     <= 1'b0;
      ex_lui       <= 1'b0;
    end
  end

  // Status: sticky illegal-opcode flag and count of decoded instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_flag <= 1'b0;
      instr_count  <= 32'h0000_0000;
    end else begin
      if (dec_illegal_s) begin
        illegal_flag <= 1'b1;
      end else begin
        illegal_flag <= illegal_flag;
      end
      if (dec_valid_s) begin
        instr_count <= instr_count + 32'd1;
      end else begin
        instr_count <= instr_count;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage. Expected ID/EX
// entries are queued when an instruction is presented and compared by a monitor
// when the stage shows a valid entry; redirects are compared combinationally.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        jump_out;
  logic [31:0] offset_out;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_alu_imm, ex_link, ex_auipc, ex_lui;
  logic        illegal_flag;
  logic [31:0] instr_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ai;
    logic        link;
    logic        auipc;
    logic        lui;
  } ent_t;

  typedef struct packed {
    ent_t        e;
    logic [31:0] cnt;
    logic        ill;
  } sb_t;

  sb_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  logic        m_illegal;
  logic [31:0] fetch_pc;
  logic [6:0]  op_tab [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  decode_stage dut (
    .clk(clk), .rst(rst), .PC(PC), .instruction(instruction),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .jump_out(jump_out), .offset_out(offset_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_imm(ex_alu_imm), .ex_link(ex_link),
    .ex_auipc(ex_auipc), .ex_lui(ex_lui), .illegal_flag(illegal_flag),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural register value as seen by a reader this cycle
  function automatic logic [31:0] rdreg(logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic void model(input logic [31:0] ins, input logic [31:0] pc,
                                output ent_t e, output logic v, output logic ill,
                                output logic j, output logic [31:0] off);
    logic [31:0] a, b, i_i, i_s, i_b, i_j, i_u;
    logic taken;
    e = '0; v = 1'b0; ill = 1'b0; j = 1'b0; off = 32'h0; taken = 1'b0;
    if (ins == 32'h0) return;
    a   = rdreg(ins[19:15]);
    b   = rdreg(ins[24:20]);
    i_i = ins[31:20] - (ins[31] ? 32'd4096 : 32'd0);
    i_s = ins[31:25] * 32'd32 + ins[11:7] - (ins[31] ? 32'd4096 : 32'd0);
    i_b = ins[7] * 32'd2048 + ins[30:25] * 32'd32 + ins[11:8] * 32'd2
          - (ins[31] ? 32'd4096 : 32'd0);
    i_j = ins[19:12] * 32'd4096 + ins[20] * 32'd2048 + ins[30:21] * 32'd2
          - (ins[31] ? 32'h0010_0000 : 32'd0);
    i_u = ins & 32'hFFFF_F000;
    v = 1'b1;
    e.pc = pc; e.rs1 = a; e.rs2 = b; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    case (ins[6:0])
      7'h37: begin e.imm = i_u; e.rd = ins[11:7]; e.rw = 1'b1; e.lui = 1'b1; end
      7'h17: begin e.imm = i_u; e.rd = ins[11:7]; e.rw = 1'b1; e.auipc = 1'b1; end
      7'h6F: begin
        e.imm = i_j; e.rd = ins[11:7]; e.rw = 1'b1; e.link = 1'b1;
        j = 1'b1; off = i_j - 32'd4;
      end
      7'h67: begin
        e.imm = i_i; e.rd = ins[11:7]; e.rw = 1'b1; e.link = 1'b1;
        j = 1'b1; off = ((a + i_i) & ~32'd1) - pc - 32'd4;
      end
      7'h63: begin
        e.imm = i_b;
        case (ins[14:12])
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: ill = 1'b1;
        endcase
        if (taken) begin j = 1'b1; off = i_b - 32'd4; end
      end
      7'h03: begin e.imm = i_i; e.rd = ins[11:7]; e.rw = 1'b1; e.mr = 1'b1; e.ai = 1'b1; end
      7'h23: begin e.imm = i_s; e.mw = 1'b1; e.ai = 1'b1; end
      7'h13: begin e.imm = i_i; e.rd = ins[11:7]; e.rw = 1'b1; e.ai = 1'b1; end
      7'h33: begin e.rd = ins[11:7]; e.rw = 1'b1; end
      7'h0F, 7'h73: begin end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      v = 1'b0; e = '0; j = 1'b0; off = 32'h0;
    end
  endfunction

  // Present one instruction (called just after a falling edge); no clock wait
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    sb_t         it;
    logic        v, ill, j;
    logic [31:0] off;
    PC = pc; instruction = ins; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    model(ins, pc, it.e, v, ill, j, off);
    check32("jump_out", {31'd0, jump_out}, {31'd0, j});
    check32("offset_out", offset_out, off);
    if (ill) m_illegal = 1'b1;
    if (v) begin
      m_count = m_count + 32'd1;
      it.cnt  = m_count;
      it.ill  = m_illegal;
      exp_q.push_back(it);
    end
    fetch_pc = pc + 32'd4 + (j ? off : 32'd0);
    if (we && wa != 5'd0) m_regs[wa] = wd;
  endtask

  task automatic cyc(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    step(pc, ins, we, wa, wd);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input logic we);
    rst = 1'b1; PC = 32'h0; instruction = 32'h0;
    wb_en = we; wb_addr = 5'd1; wb_data = 32'h5555_5555;
    @(negedge clk);
    check32("jump_in_reset", {31'd0, jump_out}, 32'd0);
    repeat (n - 1) @(negedge clk);
    rst = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_count = 32'h0; m_illegal = 1'b0; fetch_pc = 32'h0;
    check32("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check32("rst_count", instr_count, 32'd0);
    check32("rst_illegal", {31'd0, illegal_flag}, 32'd0);
    check32("rst_ex_data", ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    check32("rst_ex_ctrl", {19'd0, ex_rd, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read,
                            ex_mem_write, ex_alu_imm, ex_link, ex_auipc, ex_lui}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 40);
    if (k == 40) begin
      r[6:0] = 7'h2B;
    end else if (k == 39) begin
      r[6:0] = 7'h63; r[14:12] = 3'b011;
    end else if (k >= 35) begin
      r = 32'h0;
    end else begin
      r[6:0] = op_tab[k % 11];
      if (r[6:0] == 7'h63 && r[14:13] == 2'b01) r[14] = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard monitor: each valid ID/EX entry must match the oldest expectation
  always @(posedge clk) begin
    sb_t  x;
    ent_t got;
    #1;
    if (ex_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got ex_valid=1 pc %h expected no entry", ex_pc);
      end else begin
        x = exp_q.pop_front();
        got.pc = ex_pc; got.rs1 = ex_rs1_data; got.rs2 = ex_rs2_data; got.imm = ex_imm;
        got.rd = ex_rd; got.f3 = ex_funct3; got.f7b5 = ex_funct7b5; got.rw = ex_reg_write;
        got.mr = ex_mem_read; got.mw = ex_mem_write; got.ai = ex_alu_imm;
        got.link = ex_link; got.auipc = ex_auipc; got.lui = ex_lui;
        checks++;
        if (got !== x.e) begin
          errors++;
          $display("FAIL ex_entry: got %h expected %h", got, x.e);
        end
        check32("instr_count", instr_count, x.cnt);
        check32("illegal_flag", {31'd0, illegal_flag}, {31'd0, x.ill});
      end
    end
  end

  initial begin
    do_reset(2, 1'b0);

    // ADDI x1,x0,5
    cyc(32'h0, 32'h0050_0093, 1'b0, 5'd0, 32'h0);
    check32("addi_rd", {27'd0, ex_rd}, 32'd1);
    check32("addi_imm", ex_imm, 32'd5);
    check32("addi_alu_imm", {31'd0, ex_alu_imm}, 32'd1);
    check32("addi_count", instr_count, 32'd1);

    // ADD x3,x2,x0 with a same-cycle write-back of x2
    cyc(32'h4, 32'h0001_01B3, 1'b1, 5'd2, 32'hDEAD_BEEF);
    check32("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    cyc(32'h8, 32'h0000_01B3, 1'b1, 5'd0, 32'h7);
    check32("x0_read", ex_rs1_data, 32'd0);

    // Register setup through bubbles: x1=9, x2=9, x5=0x101
    cyc(32'hC, 32'h0, 1'b1, 5'd1, 32'd9);
    check32("bubble_valid", {31'd0, ex_valid}, 32'd0);
    cyc(32'hC, 32'h0, 1'b1, 5'd2, 32'd9);
    cyc(32'hC, 32'h0, 1'b1, 5'd5, 32'h101);

    // JAL x1,+16 at 0x20
    step(32'h20, 32'h0100_00EF, 1'b0, 5'd0, 32'h0);
    check32("jal_jump", {31'd0, jump_out}, 32'd1);
    check32("jal_offset", offset_out, 32'd12);
    check32("jal_target", PC + 32'd4 + offset_out, 32'h30);
    @(negedge clk);
    check32("jal_link", {31'd0, ex_link}, 32'd1);

    // BEQ x1,x2,-8 at 0x40, taken then not taken (x2 rewritten via bypass)
    step(32'h40, 32'hFE20_8CE3, 1'b0, 5'd0, 32'h0);
    check32("beq_offset", offset_out, 32'hFFFF_FFF4);
    check32("beq_target", PC + 32'd4 + offset_out, 32'h38);
    @(negedge clk);
    step(32'h38, 32'hFE20_8CE3, 1'b1, 5'd2, 32'd8);
    check32("beq_not_taken", {31'd0, jump_out}, 32'd0);
    @(negedge clk);

    // JALR x0,4(x5) at 0x10
    step(32'h10, 32'h0042_8067, 1'b0, 5'd0, 32'h0);
    check32("jalr_offset", offset_out, 32'h0000_00F0);
    @(negedge clk);

    // Unsupported opcode: sticky flag, entry bubbled
    cyc(32'h14, 32'h0000_007F, 1'b0, 5'd0, 32'h0);
    check32("illegal_set", {31'd0, illegal_flag}, 32'd1);
    check32("illegal_bubble", {31'd0, ex_valid}, 32'd0);
    cyc(32'h18, 32'h0050_0093, 1'b0, 5'd0, 32'h0);
    check32("illegal_sticky", {31'd0, illegal_flag}, 32'd1);

    // Random traffic with one reset (write-back asserted) in the middle
    do_reset(1, 1'b1);
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset(1, 1'b1);
      cyc(fetch_pc, rand_instr(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          $urandom);
    end
    cyc(fetch_pc, 32'h0, 1'b0, 5'd0, 32'h0);
    cyc(fetch_pc, 32'h0, 1'b0, 5'd0, 32'h0);
    check32("queue_drained", exp_q.size(), 32'd0);
    check32("final_count", instr_count, m_count);
    check32("final_illegal", {31'd0, illegal_flag}, {31'd0, m_illegal});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
